// File: rtl/shift_stack_pkg.sv
// shift_stack_pkg: shared op codes, cell select codes and operand-depth helper
package shift_stack_pkg;
  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_DUP     = 3'd3,
    OP_SWAP    = 3'd4,
    OP_ROT     = 3'd5,
    OP_REPLACE = 3'd6,
    OP_CLEAR   = 3'd7
  } op_e;
  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,
    SEL_ABOVE = 3'd1,
    SEL_BELOW = 3'd2,
    SEL_VALUE = 3'd3,
    SEL_CLEAR = 3'd4
  } sel_e;
  // Number of occupied entries an op must find before it may execute
  function automatic logic [1:0] need_of(input op_e op);
    return op == OP_ROT  ? 2'd3 :
           op == OP_SWAP ? 2'd2 :
           (op == OP_POP || op == OP_DUP || op == OP_REPLACE) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/shift_stack_cell.sv
// stack_cell: one stack word with hold / shift-in / load / clear select
module stack_cell
  import shift_stack_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  sel_e             i_sel,
  input  logic [WIDTH-1:0] i_above,
  input  logic [WIDTH-1:0] i_below,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  // Word register; the neighbour/value mux is chosen by the stack controller
  always_ff @(posedge clk) begin
    r_q <= (rst || i_sel == SEL_CLEAR) ? '0 :
           i_sel == SEL_ABOVE ? i_above :
           i_sel == SEL_BELOW ? i_below :
           i_sel == SEL_VALUE ? i_val : r_q;
  end
  assign o_q = r_q;
endmodule

// File: rtl/shift_stack.sv
// shift_stack: registered shift-register stack with sticky overflow/underflow flags
module shift_stack
  import shift_stack_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           second,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf,
  output logic                       done
);
  localparam int CW = $clog2(DEPTH+1);
  logic [CW-1:0]    r_count, w_next_count;
  logic             r_ovf, r_unf, r_done;
  op_e              w_op;
  logic             w_full, w_is_push, w_clr, w_unf_rej, w_ovf_rej, w_acc;
  logic [WIDTH-1:0] w_push_data;
  // w_ext carries one extra always-zero slot below the bottom entry so POP
  // shifts in 0 and ROT can read entry[2] safely even at the minimum depth
  logic [WIDTH-1:0] w_ext   [0:DEPTH];
  logic [WIDTH-1:0] w_above [0:DEPTH-1];
  logic [WIDTH-1:0] w_val   [0:DEPTH-1];
  sel_e             w_sel   [0:DEPTH-1];
  assign w_op        = op_e'(op);
  assign w_full      = r_count == CW'(DEPTH);
  assign w_is_push   = w_op == OP_PUSH || w_op == OP_DUP;
  assign w_clr       = en && w_op == OP_CLEAR;
  assign w_unf_rej   = en && (r_count < CW'(need_of(w_op)));
  assign w_ovf_rej   = en && w_is_push && w_full && !w_unf_rej;
  assign w_acc       = en && w_op != OP_NOP && !w_unf_rej && !w_ovf_rej;
  assign w_push_data = w_op == OP_DUP ? w_ext[0] : din;
  assign w_ext[DEPTH] = '0;
  // Per-entry select: shifts for PUSH/DUP/POP, explicit cross-links for SWAP/ROT/REPLACE
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = SEL_HOLD;
      w_val[i] = '0;
      if (w_acc) begin
        case (w_op)
          OP_PUSH, OP_DUP: w_sel[i] = SEL_ABOVE;
          OP_POP:          w_sel[i] = SEL_BELOW;
          OP_CLEAR:        w_sel[i] = SEL_CLEAR;
          OP_REPLACE: if (i == 0) begin
            w_sel[i] = SEL_VALUE;
            w_val[i] = din;
          end
          OP_SWAP: if (i < 2) begin
            w_sel[i] = SEL_VALUE;
            w_val[i] = i == 0 ? w_ext[1] : w_ext[0];
          end
          OP_ROT: if (i < 3) begin
            w_sel[i] = SEL_VALUE;
            w_val[i] = i == 0 ? w_ext[2] : i == 1 ? w_ext[0] : w_ext[1];
          end
          default: ;
        endcase
      end
    end
  end
  // Occupancy update; rejected ops leave count untouched so it never wraps
  always_comb begin
    w_next_count = !w_acc ? r_count :
                   w_clr ? '0 :
                   w_is_push ? r_count + CW'(1) :
                   w_op == OP_POP ? r_count - CW'(1) : r_count;
  end
  // Count, sticky flags and one-cycle done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_ovf   <= w_clr ? 1'b0 : (r_ovf | w_ovf_rej);
      r_unf   <= w_clr ? 1'b0 : (r_unf | w_unf_rej);
      r_done  <= w_acc;
    end
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    if (g == 0) begin : g_top
      assign w_above[g] = w_push_data;
    end else begin : g_rest
      assign w_above[g] = w_ext[g-1];
    end
    stack_cell #(.WIDTH(WIDTH)) u_cell (
      .clk     (clk),
      .rst     (rst),
      .i_sel   (w_sel[g]),
      .i_above (w_above[g]),
      .i_below (w_ext[g+1]),
      .i_val   (w_val[g]),
      .o_q     (w_ext[g])
    );
  end
  assign top    = w_ext[0];
  assign second = w_ext[1];
  assign count  = r_count;
  assign empty  = r_count == '0;
  assign full   = w_full;
  assign ovf    = r_ovf;
  assign unf    = r_unf;
  assign done   = r_done;
endmodule

// File: tb/tb_shift_stack.sv
// tb_shift_stack: directed self-checking bench for shift_stack at WIDTH=4, DEPTH=4
module tb_shift_stack;
  import shift_stack_pkg::*;
  logic       clk = 1'b0;
  logic       rst, en;
  logic [2:0] op;
  logic [3:0] din;
  logic [3:0] top, second;
  logic [2:0] count;
  logic       empty, full, ovf, unf, done;
  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  shift_stack #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .din(din),
    .top(top), .second(second), .count(count), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] o, input logic [3:0] d);
    rst = r; en = e; op = o; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input int t, input int s, input int c,
                           input int ov, input int un, input int dn);
    chk({tag, ".top"},    32'(top),    32'(t));
    chk({tag, ".second"}, 32'(second), 32'(s));
    chk({tag, ".count"},  32'(count),  32'(c));
    chk({tag, ".empty"},  32'(empty),  32'(c == 0));
    chk({tag, ".full"},   32'(full),   32'(c == 4));
    chk({tag, ".ovf"},    32'(ovf),    32'(ov));
    chk({tag, ".unf"},    32'(unf),    32'(un));
    chk({tag, ".done"},   32'(done),   32'(dn));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; op = OP_NOP; din = '0;
    step(1, 0, OP_NOP, 0);       expect_st("reset", 0, 0, 0, 0, 0, 0);
    step(0, 1, OP_PUSH, 1);      expect_st("push1", 1, 0, 1, 0, 0, 1);
    step(0, 1, OP_PUSH, 2);      expect_st("push2", 2, 1, 2, 0, 0, 1);
    step(0, 1, OP_PUSH, 3);      expect_st("push3", 3, 2, 3, 0, 0, 1);
    step(0, 1, OP_PUSH, 4);      expect_st("push4", 4, 3, 4, 0, 0, 1);
    step(0, 1, OP_PUSH, 5);      expect_st("push_full", 4, 3, 4, 1, 0, 0);
    step(0, 1, OP_NOP, 0);       expect_st("nop", 4, 3, 4, 1, 0, 0);
    // cross-link ops from a clean [4,3,2,1]
    step(1, 0, OP_NOP, 0);       expect_st("reset2", 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, OP_PUSH, 4'(i));
    expect_st("fill", 4, 3, 4, 0, 0, 1);
    step(0, 1, OP_SWAP, 0);      expect_st("swap", 3, 4, 4, 0, 0, 1);
    step(0, 1, OP_ROT, 0);       expect_st("rot", 2, 3, 4, 0, 0, 1);
    step(0, 1, OP_REPLACE, 9);   expect_st("replace", 9, 3, 4, 0, 0, 1);
    step(0, 1, OP_DUP, 0);       expect_st("dup_full", 9, 3, 4, 1, 0, 0);
    step(0, 1, OP_POP, 0);       expect_st("popa", 3, 4, 3, 1, 0, 1);
    step(0, 1, OP_POP, 0);       expect_st("popb", 4, 1, 2, 1, 0, 1);
    step(0, 1, OP_POP, 0);       expect_st("popc", 1, 0, 1, 1, 0, 1);
    step(0, 1, OP_POP, 0);       expect_st("popd", 0, 0, 0, 1, 0, 1);
    // plain pop-down with bottom zero fill
    step(1, 0, OP_NOP, 0);       expect_st("reset3", 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, OP_PUSH, 4'(i));
    step(0, 1, OP_POP, 0);       expect_st("pop1", 3, 2, 3, 0, 0, 1);
    step(0, 1, OP_POP, 0);       expect_st("pop2", 2, 1, 2, 0, 0, 1);
    step(0, 1, OP_POP, 0);       expect_st("pop3", 1, 0, 1, 0, 0, 1);
    step(0, 1, OP_POP, 0);       expect_st("pop4", 0, 0, 0, 0, 0, 1);
    // underflow handling and clear
    step(0, 1, OP_POP, 0);       expect_st("pop_empty", 0, 0, 0, 0, 1, 0);
    step(0, 1, OP_REPLACE, 6);   expect_st("repl_empty", 0, 0, 0, 0, 1, 0);
    step(0, 1, OP_PUSH, 7);      expect_st("push7", 7, 0, 1, 0, 1, 1);
    step(0, 1, OP_SWAP, 0);      expect_st("swap_unf", 7, 0, 1, 0, 1, 0);
    step(0, 1, OP_DUP, 0);       expect_st("dup", 7, 7, 2, 0, 1, 1);
    step(0, 1, OP_ROT, 0);       expect_st("rot_unf", 7, 7, 2, 0, 1, 0);
    step(0, 1, OP_PUSH, 8);      expect_st("push8", 8, 7, 3, 0, 1, 1);
    step(0, 1, OP_PUSH, 10);     expect_st("pushA", 10, 8, 4, 0, 1, 1);
    step(0, 1, OP_PUSH, 11);     expect_st("pushB_full", 10, 8, 4, 1, 1, 0);
    step(0, 1, OP_CLEAR, 0);     expect_st("clear", 0, 0, 0, 0, 0, 1);
    step(0, 1, OP_NOP, 0);       expect_st("after_clear", 0, 0, 0, 0, 0, 0);
    // enable gating and reset priority
    step(0, 1, OP_PUSH, 5);      expect_st("push5", 5, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, OP_PUSH, 4'hF); expect_st($sformatf("en_low%0d", i), 5, 0, 1, 0, 0, 0);
    end
    step(0, 0, OP_CLEAR, 0);     expect_st("en_low_clear", 5, 0, 1, 0, 0, 0);
    step(0, 1, OP_POP, 0);       step(0, 1, OP_POP, 0);
    expect_st("unf_again", 0, 0, 0, 0, 1, 0);
    step(0, 1, OP_PUSH, 3);      expect_st("push3b", 3, 0, 1, 0, 1, 1);
    step(1, 1, OP_PUSH, 4'hE);   expect_st("rst_push", 0, 0, 0, 0, 0, 0);
    step(0, 0, OP_NOP, 0);       expect_st("idle", 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/shift_stack.md
SHIFT_STACK -- requirements
Module: shift_stack

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the bit width of one stack word (legal: WIDTH >= 1).
REQ-002 Parameter DEPTH, default 8, SHALL set the number of stack entries (legal: DEPTH >= 2).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 en  in  1  SHALL qualify op; no state change when low.
REQ-006 op  in  3  SHALL select the operation per REQ-011.
REQ-007 din  in  WIDTH  SHALL be the data word for PUSH and REPLACE.
REQ-008 top, second  out  WIDTH each  SHALL present entry[0] and entry[1].
REQ-009 count  out  $clog2(DEPTH+1)  SHALL present the number of occupied entries; empty and full (out, 1 each) SHALL equal (count==0) and (count==DEPTH).
REQ-010 ovf, unf  out  1 each  SHALL be sticky overflow and underflow flags; done  out  1  SHALL pulse high for one cycle after each accepted op.

Function
REQ-011 op encoding: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 ROT (entry[2]->[0], [0]->[1], [1]->[2]), 6 REPLACE (entry[0]<=din), 7 CLEAR.
REQ-012 Priority SHALL be rst > (en==0) > op; all updates SHALL complete in one cycle, with results visible on outputs the cycle after the edge.
REQ-013 PUSH SHALL shift entries toward the bottom (entry[i+1]<=entry[i]), load din into entry[0], and increment count.
REQ-014 POP SHALL shift entries toward the top (entry[i]<=entry[i+1]), load 0 into entry[DEPTH-1], and decrement count.
REQ-015 DUP SHALL behave as PUSH with entry[0] as the data.
REQ-016 Unoccupied entries SHALL always read 0; top SHALL be 0 when empty.
REQ-017 PUSH or DUP when full SHALL leave entries and count unchanged and set ovf.
REQ-018 Any op needing more occupied entries than count holds SHALL leave state unchanged and set unf: POP/DUP/REPLACE need 1, SWAP needs 2, ROT needs 3.
REQ-019 A rejected op (REQ-017/018) SHALL NOT pulse done; NOP SHALL NOT pulse done.
REQ-020 CLEAR SHALL zero all entries, count, ovf and unf, and SHALL pulse done.
REQ-021 ovf and unf SHALL only be cleared by rst or CLEAR; they SHALL be set in the same cycle in which the rejection registers.
REQ-022 count arithmetic SHALL never wrap; count stays within 0..DEPTH.

Reset
REQ-023 On rst high at a clock edge: all entries 0, count 0, ovf 0, unf 0, done 0, regardless of en/op.
REQ-024 rst asserted mid-sequence SHALL discard the concurrent op entirely.

Structure
REQ-025 Op-code constants (OP_NOP..OP_CLEAR) SHALL live in shared package shift_stack_pkg.
REQ-026 Each entry SHALL be an instance of sub-module stack_cell (WIDTH-bit register with hold / load-from-above / load-from-below / load-value / clear select); ROT and SWAP cross-links SHALL be selected in shift_stack.
REQ-027 No combinational path SHALL exist from din/op to top, second, count, or the flag outputs.

Verification (WIDTH=4, DEPTH=4)
REQ-028 Reset, then PUSH 1, 2, 3, 4 -> top=4, second=3, count=4, full=1, done pulses x4; PUSH 5 -> state unchanged, ovf=1, no done.
REQ-029 From [4,3,2,1]: SWAP -> [3,4,2,1]; ROT -> [2,3,4,1]; REPLACE din=9 -> top=9; DUP rejected with ovf.
REQ-030 From empty: POP -> unf=1, count=0, top=0; PUSH 7, SWAP -> unf stays 1, top=7; CLEAR -> ovf=unf=0, count=0.
REQ-031 POP x4 from [4,3,2,1] -> tops 3, 2, 1, 0; empty=1; the bottom entry reads 0 after each pop.
REQ-032 en=0 with op=PUSH din=F for 3 cycles -> no change, no done; rst asserted together with PUSH -> all outputs 0 next cycle.
